mux_4to2_sched: RTL and testbench
=================================

# mux_4to2_sched

Round-robin scheduler that shares the two 8-bit lanes of the L1 4-to-2 mux stage among four input lanes. Each input lane has a valid/ready handshake and a one-entry holding register. Lanes 0/1 share output pair 1 and lanes 2/3 share output pair 2. Outputs are registered on clk_2f, with valid flags and grant identifiers for the downstream L2 stage.

## Interface
Parameters:
- DATA_W, 8, width of every data lane

Ports:
- clk_2f  in  1  fast clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = arbitration allowed; 0 = no grants issued
- lane_mask  in  4  bit i = 1 removes lane i from arbitration
- in0..in3  in  DATA_W each  lane data
- valid_bit0..valid_bit3  in  1 each  lane data valid
- ready0..ready3  out  1 each  lane i can accept data; equals ~full[i]
- data_out1  out  DATA_W  pair-1 output (lanes 0/1)
- data_out2  out  DATA_W  pair-2 output (lanes 2/3)
- valid_bit_out1, valid_bit_out2  out  1 each  output valid, one cycle per grant
- sel_out1, sel_out2  out  1 each  lane within pair that was granted (0 = even lane, 1 = odd lane)
- idle  out  1  all holding registers empty and both output valids 0

## Operation
- Holding register per lane: `full[i]` and `hold[i]` (DATA_W).
  - At an edge with valid_bit_i & ready_i: `hold[i] <= in_i`, `full[i] <= 1`.
  - A granted lane clears `full[i]` at the grant edge.
  - Capture and grant never coincide on one lane, because ready_i = 0 while full.
- Two independent arbiters, one per pair. Each has a priority pointer `ptr_p` (0 = even lane preferred).
- Eligible lane = `full & ~lane_mask`, and only when enable = 1.
- Grant rule per pair:
  - Both lanes eligible: grant the lane named by `ptr_p`.
  - One lane eligible: grant that lane.
  - No lane eligible: no grant.
- On a grant at an edge:
  - data_out_p <= hold[granted]
  - valid_bit_out_p <= 1
  - sel_out_p <= granted index within pair
  - ptr_p <= the other lane of the pair
  - full[granted] <= 0
- With no grant: valid_bit_out_p <= 0; data_out_p, sel_out_p and ptr_p hold.
- enable = 0:
  - No grants; valid outputs go 0 at the next edge.
  - Holding registers still capture; pointers are frozen.
- Masked lane: its data stays held and ready stays 0 while full. It is granted again after unmask, from the next edge.
- lane_mask and enable changes take effect on the edge where they are first sampled.
- Reset (sampled at an edge) forces:
  - full = 0, hold = 0, ptr = 0
  - data_out1/2 = 0, valid_bit_out1/2 = 0, sel_out1/2 = 0
- After reset: ready0..3 = 1 and idle = 1. Reset dominates simultaneous valid inputs.
- Reset mid-operation discards all held data; no partial output is produced.

## Timing
- Latency: data accepted at edge N, if granted at the first opportunity, appears on data_out with valid at edge N+1 (visible in the cycle after N+1).
- Per-lane throughput: at most one word per 2 cycles (accept, then grant).
- Per-pair throughput: one word per cycle when both lanes alternate.
- Fairness: with both lanes of a pair continuously eligible, grants strictly alternate. Maximum wait for an eligible unmasked lane is 1 grant of its partner.
- Outputs are registered.
- ready_i and idle are combinational from registers only, with no input-to-output combinational path.

## Test plan
- Reset, then lane 0 only: in0 = 0xA5 with valid at edge 1 → valid_bit_out1 = 1, data_out1 = 0xA5, sel_out1 = 0 after edge 2; ready0 = 0 between edges 1 and 2; idle = 1 after edge 3.
- Lanes 0 and 1 loaded at the same edge with 0x11 and 0x22 → pair 1 emits 0x11 (sel 0), then 0x22 (sel 1) on consecutive cycles. A following reload of both starts with lane 0 again, since ptr returned to 0.
- All four lanes loaded with 0x01..0x04 → pairs are independent: cycle 1 gives out1 = 0x01 and out2 = 0x03; cycle 2 gives out1 = 0x02 and out2 = 0x04.
- lane_mask = 4'b0010 with lanes 0 and 1 full (0x33, 0x44) → only 0x33 emitted and ready1 stays 0. Clearing the mask → 0x44 emitted on the following edge with sel_out1 = 1.
- enable = 0 with lane 2 full (0x5A) → valid_bit_out2 stays 0 for 5 cycles; enable = 1 → 0x5A emitted at the next edge.
- Reset asserted while lanes 0 and 3 are full → after the reset edge, all valid outputs are 0, data_out = 0, ready0..3 = 1 and idle = 1, with no stale data emitted.

Source files
------------

// File: rtl/mux_4to2_sched.sv
// Round-robin 4-to-2 lane scheduler: four buffered input lanes
// share two registered 8-bit output pairs (lanes 0/1 and 2/3).

module mux_4to2_sched_arb (
   input  logic [1:0] i_elig,
   input  logic       i_ptr,
   output logic       o_gnt,
   output logic       o_sel
);

   always_comb begin
      o_gnt = |i_elig;
      o_sel = 1'b0;
      case (i_elig)
         2'b11:   o_sel = i_ptr;
         2'b10:   o_sel = 1'b1;
         default: o_sel = 1'b0;
      endcase
   end

endmodule

module mux_4to2_sched #(
   parameter int DATA_W = 8
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              enable,
   input  logic [3:0]        lane_mask,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic              valid_bit0,
   input  logic              valid_bit1,
   input  logic              valid_bit2,
   input  logic              valid_bit3,
   output logic              ready0,
   output logic              ready1,
   output logic              ready2,
   output logic              ready3,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic              valid_bit_out1,
   output logic              valid_bit_out2,
   output logic              sel_out1,
   output logic              sel_out2,
   output logic              idle
);

   logic [DATA_W-1:0] w_in [4];
   logic [3:0]        w_vld;
   logic [3:0]        w_elig;
   logic [3:0]        w_cap;
   logic [3:0]        w_clr;
   logic [1:0]        w_gnt;
   logic [1:0]        w_gsel;
   logic [DATA_W-1:0] w_gdata [2];

   logic [3:0]        r_full;
   logic [DATA_W-1:0] r_hold [4];
   logic [1:0]        r_ptr;
   logic [DATA_W-1:0] r_dout [2];
   logic [1:0]        r_vout;
   logic [1:0]        r_sel;

   assign w_in[0] = in0;
   assign w_in[1] = in1;
   assign w_in[2] = in2;
   assign w_in[3] = in3;
   assign w_vld   = {valid_bit3, valid_bit2,
                     valid_bit1, valid_bit0};

   // Capture only into an empty slot, so capture and grant never collide.
   assign w_cap  = w_vld & ~r_full;
   assign w_elig = r_full & ~lane_mask & {4{enable}};

   for (genvar p = 0; p < 2; p++) begin : g_pair
      mux_4to2_sched_arb u_arb (
         .i_elig (w_elig[2*p+1 -: 2]),
         .i_ptr  (r_ptr[p]),
         .o_gnt  (w_gnt[p]),
         .o_sel  (w_gsel[p])
      );

      assign w_clr[2*p]   = w_gnt[p] & ~w_gsel[p];
      assign w_clr[2*p+1] = w_gnt[p] &  w_gsel[p];
      assign w_gdata[p]   = w_gsel[p] ? r_hold[2*p+1]
                                      : r_hold[2*p];
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         r_full <= '0;
         r_ptr  <= '0;
         r_vout <= '0;
         r_sel  <= '0;
         for (int i = 0; i < 4; i++) begin
            r_hold[i] <= '0;
         end
         for (int p = 0; p < 2; p++) begin
            r_dout[p] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_cap[i]) begin
               r_full[i] <= 1'b1;
               r_hold[i] <= w_in[i];
            end else if (w_clr[i]) begin
               r_full[i] <= 1'b0;
            end
         end
         for (int p = 0; p < 2; p++) begin
            r_vout[p] <= w_gnt[p];
            if (w_gnt[p]) begin
               r_dout[p] <= w_gdata[p];
               r_sel[p]  <= w_gsel[p];
               r_ptr[p]  <= ~w_gsel[p];
            end
         end
      end
   end

   assign ready0 = ~r_full[0];
   assign ready1 = ~r_full[1];
   assign ready2 = ~r_full[2];
   assign ready3 = ~r_full[3];

   assign data_out1      = r_dout[0];
   assign data_out2      = r_dout[1];
   assign valid_bit_out1 = r_vout[0];
   assign valid_bit_out2 = r_vout[1];
   assign sel_out1       = r_sel[0];
   assign sel_out2       = r_sel[1];

   assign idle = ~|r_full & ~|r_vout;

endmodule

// File: tb/tb_mux_4to2_sched.sv
// Directed bench for mux_4to2_sched: hand-computed vectors
// covering latency, fairness, masking, enable and reset.

module tb_mux_4to2_sched;

   logic       clk_2f = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] lane_mask;
   logic [7:0] in0, in1, in2, in3;
   logic       valid_bit0, valid_bit1, valid_bit2, valid_bit3;
   logic       ready0, ready1, ready2, ready3;
   logic [7:0] data_out1, data_out2;
   logic       valid_bit_out1, valid_bit_out2;
   logic       sel_out1, sel_out2;
   logic       idle;

   int n_chk  = 0;
   int n_pass = 0;

   mux_4to2_sched #(.DATA_W(8)) dut (
      .clk_2f         (clk_2f),
      .reset          (reset),
      .enable         (enable),
      .lane_mask      (lane_mask),
      .in0            (in0),
      .in1            (in1),
      .in2            (in2),
      .in3            (in3),
      .valid_bit0     (valid_bit0),
      .valid_bit1     (valid_bit1),
      .valid_bit2     (valid_bit2),
      .valid_bit3     (valid_bit3),
      .ready0         (ready0),
      .ready1         (ready1),
      .ready2         (ready2),
      .ready3         (ready3),
      .data_out1      (data_out1),
      .data_out2      (data_out2),
      .valid_bit_out1 (valid_bit_out1),
      .valid_bit_out2 (valid_bit_out2),
      .sel_out1       (sel_out1),
      .sel_out2       (sel_out2),
      .idle           (idle)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   // One rising edge, then settle; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk_2f);
      #1;
   endtask

   task automatic clr_valid();
      valid_bit0 = 0; valid_bit1 = 0;
      valid_bit2 = 0; valid_bit3 = 0;
   endtask

   task automatic do_reset();
      reset = 1; clr_valid();
      tick();
      reset = 0;
   endtask

   function automatic logic [3:0] rdy();
      return {ready3, ready2, ready1, ready0};
   endfunction

   initial begin
      reset = 1; enable = 1; lane_mask = 4'h0;
      in0 = 0; in1 = 0; in2 = 0; in3 = 0;
      clr_valid();

      // reset state
      do_reset();
      check("rst_ready", 32'(rdy()), 32'hF);
      check("rst_idle", 32'(idle), 1);
      check("rst_vout1", 32'(valid_bit_out1), 0);
      check("rst_vout2", 32'(valid_bit_out2), 0);
      check("rst_dout1", 32'(data_out1), 0);

      // single lane latency
      in0 = 8'hA5; valid_bit0 = 1;
      tick();
      clr_valid();
      check("l0_ready0", 32'(ready0), 0);
      check("l0_vout_early", 32'(valid_bit_out1), 0);
      check("l0_idle_busy", 32'(idle), 0);
      tick();
      check("l0_vout", 32'(valid_bit_out1), 1);
      check("l0_dout", 32'(data_out1), 32'hA5);
      check("l0_sel", 32'(sel_out1), 0);
      check("l0_ready0_back", 32'(ready0), 1);
      check("l0_vout2", 32'(valid_bit_out2), 0);
      tick();
      check("l0_idle", 32'(idle), 1);
      check("l0_vout_drop", 32'(valid_bit_out1), 0);

      // pair fairness and pointer wrap
      do_reset();
      in0 = 8'h11; in1 = 8'h22;
      valid_bit0 = 1; valid_bit1 = 1;
      tick();
      clr_valid();
      tick();
      check("rr_a_dout", 32'(data_out1), 32'h11);
      check("rr_a_sel", 32'(sel_out1), 0);
      tick();
      check("rr_b_vout", 32'(valid_bit_out1), 1);
      check("rr_b_dout", 32'(data_out1), 32'h22);
      check("rr_b_sel", 32'(sel_out1), 1);
      in0 = 8'h55; in1 = 8'h66;
      valid_bit0 = 1; valid_bit1 = 1;
      tick();
      clr_valid();
      tick();
      check("rr_c_dout", 32'(data_out1), 32'h55);
      check("rr_c_sel", 32'(sel_out1), 0);
      tick();
      check("rr_d_dout", 32'(data_out1), 32'h66);
      check("rr_d_sel", 32'(sel_out1), 1);

      // independent pairs
      do_reset();
      in0 = 8'h01; in1 = 8'h02; in2 = 8'h03; in3 = 8'h04;
      valid_bit0 = 1; valid_bit1 = 1;
      valid_bit2 = 1; valid_bit3 = 1;
      tick();
      clr_valid();
      check("ind_ready", 32'(rdy()), 0);
      tick();
      check("ind1_out1", 32'(data_out1), 32'h01);
      check("ind1_out2", 32'(data_out2), 32'h03);
      check("ind1_vout2", 32'(valid_bit_out2), 1);
      check("ind1_sel2", 32'(sel_out2), 0);
      tick();
      check("ind2_out1", 32'(data_out1), 32'h02);
      check("ind2_out2", 32'(data_out2), 32'h04);
      check("ind2_sel2", 32'(sel_out2), 1);
      check("ind_ready_back", 32'(rdy()), 32'hF);

      // lane mask
      do_reset();
      lane_mask = 4'b0010;
      in0 = 8'h33; in1 = 8'h44;
      valid_bit0 = 1; valid_bit1 = 1;
      tick();
      clr_valid();
      tick();
      check("msk_dout", 32'(data_out1), 32'h33);
      check("msk_sel", 32'(sel_out1), 0);
      tick();
      check("msk_vout_off", 32'(valid_bit_out1), 0);
      check("msk_ready1", 32'(ready1), 0);
      lane_mask = 4'b0000;
      tick();
      check("unmsk_vout", 32'(valid_bit_out1), 1);
      check("unmsk_dout", 32'(data_out1), 32'h44);
      check("unmsk_sel", 32'(sel_out1), 1);
      check("unmsk_ready1", 32'(ready1), 1);

      // enable gating
      do_reset();
      enable = 0;
      in2 = 8'h5A; valid_bit2 = 1;
      tick();
      clr_valid();
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("en_off_vout2_%0d", k),
               32'(valid_bit_out2), 0);
      end
      check("en_off_ready2", 32'(ready2), 0);
      enable = 1;
      tick();
      check("en_on_vout2", 32'(valid_bit_out2), 1);
      check("en_on_dout2", 32'(data_out2), 32'h5A);
      check("en_on_sel2", 32'(sel_out2), 0);

      // reset mid-operation
      do_reset();
      enable = 0;
      in0 = 8'hC3; in3 = 8'h3C;
      valid_bit0 = 1; valid_bit3 = 1;
      tick();
      clr_valid();
      check("mid_ready", 32'(rdy()), 32'b0110);
      enable = 1;
      reset = 1;
      valid_bit1 = 1; in1 = 8'h77;
      tick();
      reset = 0;
      clr_valid();
      check("mid_vout1", 32'(valid_bit_out1), 0);
      check("mid_vout2", 32'(valid_bit_out2), 0);
      check("mid_dout1", 32'(data_out1), 0);
      check("mid_dout2", 32'(data_out2), 0);
      check("mid_ready_rst", 32'(rdy()), 32'hF);
      check("mid_idle", 32'(idle), 1);
      tick();
      check("mid_stale1", 32'(valid_bit_out1), 0);
      check("mid_stale2", 32'(valid_bit_out2), 0);
      check("mid_idle2", 32'(idle), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
